mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, data memory depth as 2^DEPTH_LOG2 32-bit words.
REQ-002 SHALL have port clock  in  1  single clock; all state updates on posedge clock.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port WBin  in  2  writeback control from EX/MEM, passed through.
REQ-005 SHALL have port MEMin  in  3  {Branch, MemRead, MemWrite} from EX/MEM; Branch is ignored by this block.
REQ-006 SHALL have port accSize  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 SHALL have port accUnsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
REQ-008 SHALL have port ALUin  in  32  byte address for memory ops; result otherwise.
REQ-009 SHALL have port WriteDataM  in  32  store data, low bits used for byte/half.
REQ-010 SHALL have port RegRDin  in  5  destination register.
REQ-011 SHALL have outputs WBreg[1:0], ALUreg[31:0], ReadDataW[31:0], RegRDreg[4:0]: the MEM/WB register contents.
REQ-012 SHALL have output stall  1  combinational; upstream holds EX/MEM contents while high.
REQ-013 SHALL have output misalign  1  registered one-cycle fault pulse.

Function
REQ-014 SHALL implement FSM states IDLE and WAIT; reset state IDLE.
REQ-015 Memory op = MemRead|MemWrite. Aligned = byte any address; half needs ALUin[0]=0; word needs ALUin[1:0]=00.
REQ-016 stall SHALL equal (state==IDLE) & memop & aligned; stall SHALL be 0 in WAIT.
REQ-017 IDLE, no memop: at the edge, the outputs SHALL load WBin, ALUin and RegRDin, and ReadDataW SHALL load 0 (latency 1).
REQ-018 IDLE, aligned memop: at the edge, state SHALL go to WAIT and the outputs SHALL load a bubble (WBreg=0, RegRDreg=0, ALUreg=0, ReadDataW=0).
REQ-019 WAIT: at the edge, the block SHALL perform the access using the held inputs, load the outputs (WBin/ALUin/RegRDin, ReadDataW = load result or 0), and return to IDLE; total memop latency is 2 edges.
REQ-020 The word index SHALL be ALUin[DEPTH_LOG2+1:2]; higher address bits SHALL be ignored (wrap-around).
REQ-021 Stores SHALL be little-endian and write only the addressed lanes: byte lane ALUin[1:0] gets WriteDataM[7:0]; half lanes {ALUin[1],0} and +1 get WriteDataM[15:0]; word writes all four lanes.
REQ-022 Loads SHALL extract the addressed byte/half little-endian and extend it to 32 bits per accUnsigned; word loads SHALL be returned unchanged.
REQ-023 MemRead and MemWrite both 1 SHALL perform the store only, with ReadDataW=0.
REQ-024 Misaligned memop in IDLE: no stall, no memory access; at the edge the outputs SHALL load a bubble and misalign SHALL be 1 for exactly that cycle, otherwise 0.
REQ-025 A memop presented in IDLE the edge after WAIT SHALL restart the sequence (back-to-back ops: stall high every other cycle).
REQ-026 Memory contents SHALL initialize to zero at time 0.

Reset
REQ-027 reset=1 at an edge SHALL force state IDLE, all outputs 0 and misalign 0, overriding all other behaviour.
REQ-028 reset asserted while in WAIT SHALL abort the access; a pending store SHALL NOT modify memory.
REQ-029 Memory contents SHALL NOT be altered by reset.
REQ-030 stall SHALL be 0 during the reset cycle's output state (state is IDLE only after the edge; stall is evaluated from the current state).

Verification
REQ-031 Word store then load: MemWrite, word, addr 0x10, data 0xDEADBEEF; then MemRead, word, 0x10 -> stall high 1 cycle each; ReadDataW=0xDEADBEEF 2 edges after the load is presented.
REQ-032 Byte sign/zero extension: word 0x000000F0 at 0x20; byte load 0x20 signed -> 0xFFFFFFF0; unsigned -> 0x000000F0.
REQ-033 Partial store: word 0x11223344 at 0x30; half store 0xAABB at 0x32; word load -> 0xAABB3344.
REQ-034 Misalign: word load at 0x41 -> stall 0, misalign=1 for one cycle, WBreg=0, memory unchanged.
REQ-035 Reset mid-op: word store 0x12345678 to 0x50 with reset asserted in WAIT -> outputs 0; later load 0x50 -> 0x00000000.
REQ-036 Passthrough/wrap: non-mem ALUin=0x7, WBin=2'b10, RegRDin=5 -> outputs next edge, ReadDataW=0; a store to 0x400 (DEPTH_LOG2=8) is readable at 0x0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-lane data memory with a two-edge access and the MEM/WB register.
// An aligned memory op stalls upstream for one cycle (IDLE->WAIT); a misaligned op is dropped with a fault pulse.
module mem_stage #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  WBin,
  input  logic [2:0]  MEMin,
  input  logic [1:0]  accSize,
  input  logic        accUnsigned,
  input  logic [31:0] ALUin,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RegRDin,
  output logic [1:0]  WBreg,
  output logic [31:0] ALUreg,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RegRDreg,
  output logic        stall,
  output logic        misalign
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [1:0]  wb_q, wb_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        misalign_q, misalign_d;

  logic        mem_rd, mem_wr, memop, aligned;
  logic [3:0]  lane_sel, lane_we;
  logic [31:0] wdata_lanes, rd_word, load_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic        unused_branch;

  assign unused_branch = MEMin[2];
  assign mem_rd   = MEMin[1];
  assign mem_wr   = MEMin[0];
  assign memop    = mem_rd | mem_wr;
  assign word_idx = ALUin[DEPTH_LOG2+1:2];

  // Store data is replicated across lanes so each lane just picks its own byte.
  always_comb begin
    aligned     = 1'b1;
    lane_sel    = 4'b1111;
    wdata_lanes = WriteDataM;
    case (accSize)
      2'b00: begin
        lane_sel    = 4'b0001 << ALUin[1:0];
        wdata_lanes = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        aligned     = ~ALUin[0];
        lane_sel    = ALUin[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{WriteDataM[15:0]}};
      end
      default: aligned = (ALUin[1:0] == 2'b00);
    endcase
  end

  assign lane_we = (state_q == ST_WAIT && !reset && mem_wr) ? lane_sel : 4'b0000;

  // Inputs are held through the stall, so the read issued at the IDLE edge is valid in WAIT.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] ram [DEPTH] = '{default: 8'h00};
      logic [7:0] rd_byte_q;
      always_ff @(posedge clock) begin
        if (lane_we[gi]) begin
          ram[word_idx] <= wdata_lanes[8*gi +: 8];
        end
        rd_byte_q <= ram[word_idx];
      end
      assign rd_word[8*gi +: 8] = rd_byte_q;
    end
  endgenerate

  assign byte_sel = rd_word[{ALUin[1:0], 3'b000} +: 8];
  assign half_sel = ALUin[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (accSize)
      2'b00:   load_val = {{24{~accUnsigned & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{~accUnsigned & half_sel[15]}}, half_sel};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wb_d       = WBin;
    alu_d      = ALUin;
    rd_d       = RegRDin;
    rdata_d    = 32'h0;
    misalign_d = 1'b0;
    if (state_q == ST_WAIT) begin
      state_d = ST_IDLE;
      if (mem_rd && !mem_wr) begin
        rdata_d = load_val;
      end
    end else if (memop) begin
      wb_d  = 2'b00;
      alu_d = 32'h0;
      rd_d  = 5'd0;
      if (aligned) begin
        state_d = ST_WAIT;
      end else begin
        misalign_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wb_q       <= 2'b00;
      alu_q      <= 32'h0;
      rdata_q    <= 32'h0;
      rd_q       <= 5'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_q       <= wb_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
      rd_q       <= rd_d;
      misalign_q <= misalign_d;
    end
  end

  assign stall     = (state_q == ST_IDLE) & memop & aligned;
  assign WBreg     = wb_q;
  assign ALUreg    = alu_q;
  assign ReadDataW = rdata_q;
  assign RegRDreg  = rd_q;
  assign misalign  = misalign_q;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random ops against a byte-array memory model.
module tb_mem_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  WBin;
  logic [2:0]  MEMin;
  logic [1:0]  accSize;
  logic        accUnsigned;
  logic [31:0] ALUin;
  logic [31:0] WriteDataM;
  logic [4:0]  RegRDin;
  logic [1:0]  WBreg;
  logic [31:0] ALUreg;
  logic [31:0] ReadDataW;
  logic [4:0]  RegRDreg;
  logic        stall;
  logic        misalign;

  int passed = 0;
  int total  = 0;

  // Reference memory: 256 words seen as 1024 little-endian bytes.
  logic [7:0] model_mem [1024];

  typedef struct {
    logic        st0, st1, mis1, mis;
    logic [1:0]  wb1, wb;
    logic [31:0] alu1, alu, rdat1, rdat;
    logic [4:0]  rd1, rd;
  } obs_t;

  mem_stage #(.DEPTH_LOG2(8)) dut (
    .clock(clock), .reset(reset), .WBin(WBin), .MEMin(MEMin), .accSize(accSize),
    .accUnsigned(accUnsigned), .ALUin(ALUin), .WriteDataM(WriteDataM), .RegRDin(RegRDin),
    .WBreg(WBreg), .ALUreg(ALUreg), .ReadDataW(ReadDataW), .RegRDreg(RegRDreg),
    .stall(stall), .misalign(misalign)
  );

  always #5 clock = ~clock;

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
    int n = size_bytes(sz);
    int a = int'(addr % 1024);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(model_mem[a + i]) << (8 * i));
    if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data);
    int n = size_bytes(sz);
    int a = int'(addr % 1024);
    for (int i = 0; i < n; i++) model_mem[a + i] = 8'(data >> (8 * i));
  endtask

  // Presents one op at a negedge and captures what the DUT shows; returns at a negedge.
  task automatic issue(input logic [1:0] wb, input logic [2:0] mem, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, output obs_t o);
    WBin = wb; MEMin = mem; accSize = sz; accUnsigned = uns;
    ALUin = addr; WriteDataM = wd; RegRDin = rd;
    #1 o.st0 = stall;
    @(posedge clock); @(negedge clock);
    o.wb1 = WBreg; o.alu1 = ALUreg; o.rdat1 = ReadDataW; o.rd1 = RegRDreg;
    o.mis1 = misalign; o.st1 = stall;
    if (o.st0) begin
      @(posedge clock); @(negedge clock);
    end
    o.wb = WBreg; o.alu = ALUreg; o.rdat = ReadDataW; o.rd = RegRDreg; o.mis = misalign;
    MEMin = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b1; WBin = 2'b11; MEMin = 3'b010; accSize = 2'b10; accUnsigned = 1'b0;
    ALUin = 32'h0000_0010; WriteDataM = 32'hFFFF_FFFF; RegRDin = 5'd31;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++;
    if ({WBreg, ALUreg, ReadDataW, RegRDreg, misalign} !== 72'h0) begin
      $display("FAIL reset_outputs: got wb=%h alu=%h rdat=%h rd=%h mis=%b, want all 0",
               WBreg, ALUreg, ReadDataW, RegRDreg, misalign);
    end else passed++;
    MEMin = 3'b000; reset = 1'b0;
    #1;
    total++;
    if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall);
    else passed++;
    $display("reset: outputs cleared");
  endtask

  task automatic test_word_store_load();
    obs_t o;
    issue(2'b01, 3'b001, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd3, o);
    ref_store(32'h10, 2'b10, 32'hDEAD_BEEF);
    total++;
    if ({o.st0, o.st1, o.wb1, o.rd1, o.alu1} !== {1'b1, 1'b0, 2'b00, 5'd0, 32'h0})
      $display("FAIL store_stall_bubble: got st=%b%b wb=%h rd=%0d alu=%h want st=10 bubble",
               o.st0, o.st1, o.wb1, o.rd1, o.alu1);
    else passed++;
    issue(2'b11, 3'b010, 2'b10, 1'b0, 32'h10, 32'h0, 5'd9, o);
    total++;
    if ({o.st0, o.rdat1, o.rdat, o.wb, o.rd, o.alu} !== {1'b1, 32'h0, 32'hDEAD_BEEF, 2'b11, 5'd9, 32'h10})
      $display("FAIL word_load: got st=%b rdat1=%h rdat=%h wb=%h rd=%0d alu=%h want 1 0 deadbeef 3 9 10",
               o.st0, o.rdat1, o.rdat, o.wb, o.rd, o.alu);
    else passed++;
    $display("word store/load 0x10: rdat=%h", o.rdat);
  endtask

  task automatic test_sign_ext();
    obs_t o;
    issue(2'b01, 3'b001, 2'b10, 1'b0, 32'h20, 32'h0000_00F0, 5'd1, o);
    ref_store(32'h20, 2'b10, 32'h0000_00F0);
    issue(2'b01, 3'b010, 2'b00, 1'b0, 32'h20, 32'h0, 5'd2, o);
    total++;
    if (o.rdat !== 32'hFFFF_FFF0) $display("FAIL byte_signed: got %h want fffffff0", o.rdat);
    else passed++;
    issue(2'b01, 3'b010, 2'b00, 1'b1, 32'h20, 32'h0, 5'd2, o);
    total++;
    if (o.rdat !== 32'h0000_00F0) $display("FAIL byte_unsigned: got %h want 000000f0", o.rdat);
    else passed++;
    $display("byte extension at 0x20: unsigned=%h", o.rdat);
  endtask

  task automatic test_partial_store();
    obs_t o;
    issue(2'b00, 3'b001, 2'b10, 1'b0, 32'h30, 32'h1122_3344, 5'd0, o);
    ref_store(32'h30, 2'b10, 32'h1122_3344);
    issue(2'b00, 3'b001, 2'b01, 1'b0, 32'h32, 32'h5555_AABB, 5'd0, o);
    ref_store(32'h32, 2'b01, 32'h5555_AABB);
    issue(2'b00, 3'b010, 2'b10, 1'b0, 32'h30, 32'h0, 5'd4, o);
    total++;
    if (o.rdat !== 32'hAABB_3344) $display("FAIL partial_store: got %h want aabb3344", o.rdat);
    else passed++;
    // Read and write together: store happens, ReadDataW stays 0.
    issue(2'b10, 3'b011, 2'b10, 1'b0, 32'h60, 32'h55AA_55AA, 5'd6, o);
    ref_store(32'h60, 2'b10, 32'h55AA_55AA);
    total++;
    if (o.rdat !== 32'h0) $display("FAIL rw_both_rdata: got %h want 0", o.rdat);
    else passed++;
    issue(2'b10, 3'b010, 2'b10, 1'b0, 32'h60, 32'h0, 5'd6, o);
    total++;
    if (o.rdat !== 32'h55AA_55AA) $display("FAIL rw_both_store: got %h want 55aa55aa", o.rdat);
    else passed++;
    $display("partial store 0x32 and rw-both 0x60 done");
  endtask

  task automatic test_misalign();
    obs_t o;
    issue(2'b11, 3'b010, 2'b10, 1'b0, 32'h41, 32'h0, 5'd7, o);
    total++;
    if ({o.st0, o.mis1, o.wb1, o.rd1, o.alu1, o.rdat1} !== {1'b0, 1'b1, 2'b00, 5'd0, 32'h0, 32'h0})
      $display("FAIL misalign_pulse: got st=%b mis=%b wb=%h rd=%0d alu=%h want 0 1 bubble",
               o.st0, o.mis1, o.wb1, o.rd1, o.alu1);
    else passed++;
    @(posedge clock); @(negedge clock);
    total++;
    if (misalign !== 1'b0) $display("FAIL misalign_one_cycle: got %b want 0", misalign);
    else passed++;
    issue(2'b00, 3'b001, 2'b10, 1'b0, 32'h42, 32'hFFFF_FFFF, 5'd0, o);
    issue(2'b00, 3'b001, 2'b01, 1'b0, 32'h43, 32'hFFFF_FFFF, 5'd0, o);
    total++;
    if ({o.st0, o.mis1} !== 2'b01) $display("FAIL misalign_half: got st=%b mis=%b want 0 1", o.st0, o.mis1);
    else passed++;
    issue(2'b00, 3'b010, 2'b10, 1'b0, 32'h40, 32'h0, 5'd0, o);
    total++;
    if (o.rdat !== 32'h0) $display("FAIL misalign_no_write: got %h want 0", o.rdat);
    else passed++;
    $display("misalign 0x41: pulse seen, memory at 0x40 = %h", o.rdat);
  endtask

  task automatic test_reset_midop();
    obs_t o;
    WBin = 2'b11; MEMin = 3'b001; accSize = 2'b10; accUnsigned = 1'b0;
    ALUin = 32'h50; WriteDataM = 32'h1234_5678; RegRDin = 5'd8;
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL midop_stall: got %b want 1", stall);
    else passed++;
    @(posedge clock); @(negedge clock);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    total++;
    if ({WBreg, ALUreg, ReadDataW, RegRDreg, misalign} !== 72'h0)
      $display("FAIL midop_reset_outputs: got wb=%h alu=%h rdat=%h rd=%0d want all 0",
               WBreg, ALUreg, ReadDataW, RegRDreg);
    else passed++;
    MEMin = 3'b000; reset = 1'b0;
    @(posedge clock); @(negedge clock);
    issue(2'b00, 3'b010, 2'b10, 1'b0, 32'h50, 32'h0, 5'd0, o);
    total++;
    if (o.rdat !== 32'h0) $display("FAIL midop_aborted_store: got %h want 0", o.rdat);
    else passed++;
    $display("reset in WAIT: store to 0x50 aborted, read %h", o.rdat);
  endtask

  task automatic test_passthrough_wrap();
    obs_t o;
    issue(2'b10, 3'b000, 2'b10, 1'b0, 32'h7, 32'hFFFF_FFFF, 5'd5, o);
    total++;
    if ({o.st0, o.wb1, o.alu1, o.rd1, o.rdat1, o.mis1} !== {1'b0, 2'b10, 32'h7, 5'd5, 32'h0, 1'b0})
      $display("FAIL passthrough: got st=%b wb=%h alu=%h rd=%0d rdat=%h want 0 2 7 5 0",
               o.st0, o.wb1, o.alu1, o.rd1, o.rdat1);
    else passed++;
    issue(2'b01, 3'b100, 2'b10, 1'b0, 32'h44, 32'h0, 5'd12, o);
    total++;
    if ({o.st0, o.wb1, o.alu1, o.rd1} !== {1'b0, 2'b01, 32'h44, 5'd12})
      $display("FAIL branch_ignored: got st=%b wb=%h alu=%h rd=%0d", o.st0, o.wb1, o.alu1, o.rd1);
    else passed++;
    issue(2'b00, 3'b001, 2'b10, 1'b0, 32'h400, 32'hCAFE_F00D, 5'd0, o);
    ref_store(32'h400, 2'b10, 32'hCAFE_F00D);
    issue(2'b00, 3'b010, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, o);
    total++;
    if (o.rdat !== 32'hCAFE_F00D) $display("FAIL wrap_0x400: got %h want cafef00d", o.rdat);
    else passed++;
    $display("passthrough and wrap: 0x0 reads %h", o.rdat);
  endtask

  task automatic test_random();
    obs_t o;
    logic [1:0]  wb, sz;
    logic [2:0]  mem;
    logic        uns, is_mem, ok;
    logic [31:0] addr, wd, exp_rdat;
    logic [4:0]  rd;
    for (int t = 0; t < 60; t++) begin
      wb = 2'($urandom); mem = 3'($urandom); sz = 2'($urandom); uns = 1'($urandom);
      addr = $urandom & 32'h0000_0C3F; wd = $urandom; rd = 5'($urandom);
      is_mem = mem[1] | mem[0];
      ok = (addr % size_bytes(sz)) == 0;
      exp_rdat = (mem[1] && !mem[0]) ? ref_load(addr, sz, uns) : 32'h0;
      issue(wb, mem, sz, uns, addr, wd, rd, o);
      total++;
      if (!is_mem) begin
        if ({o.st0, o.wb1, o.alu1, o.rd1, o.rdat1, o.mis1} !== {1'b0, wb, addr, rd, 32'h0, 1'b0})
          $display("FAIL rand_pass[%0d]: got st=%b wb=%h alu=%h rd=%0d rdat=%h mis=%b want 0 %h %h %0d 0 0",
                   t, o.st0, o.wb1, o.alu1, o.rd1, o.rdat1, o.mis1, wb, addr, rd);
        else passed++;
      end else if (!ok) begin
        if ({o.st0, o.wb1, o.alu1, o.rd1, o.rdat1, o.mis1} !== {1'b0, 2'b00, 32'h0, 5'd0, 32'h0, 1'b1})
          $display("FAIL rand_misalign[%0d]: got st=%b wb=%h alu=%h rd=%0d mis=%b want 0 bubble 1",
                   t, o.st0, o.wb1, o.alu1, o.rd1, o.mis1);
        else passed++;
      end else begin
        if ({o.st0, o.st1, o.wb1, o.alu1, o.rd1, o.wb, o.alu, o.rd, o.rdat, o.mis}
            !== {1'b1, 1'b0, 2'b00, 32'h0, 5'd0, wb, addr, rd, exp_rdat, 1'b0})
          $display("FAIL rand_memop[%0d]: got st=%b%b wb=%h alu=%h rd=%0d rdat=%h want st=10 %h %h %0d %h",
                   t, o.st0, o.st1, o.wb, o.alu, o.rd, o.rdat, wb, addr, rd, exp_rdat);
        else passed++;
        if (mem[0]) ref_store(addr, sz, wd);
      end
      $display("rand %0d: mem=%b sz=%0d addr=%h wd=%h -> rdat=%h", t, mem, sz, addr, wd, o.rdat);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;
    reset = 1'b1; WBin = 0; MEMin = 0; accSize = 0; accUnsigned = 0;
    ALUin = 0; WriteDataM = 0; RegRDin = 0;
    @(negedge clock);
    test_reset();
    test_word_store_load();
    test_sign_ext();
    test_partial_store();
    test_misalign();
    test_reset_midop();
    test_passthrough_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
